// File: rtl/ycbcr_frame_arbiter.sv
// Frame-granular arbiter sharing one pipelined RGB888->YCbCr converter between two
// pixel sources; grants whole frames, drains the pipeline and tags results by owner.
module ycbcr_frame_arbiter #(
   parameter int unsigned PIX_PER_FRAME = 307200,
   parameter int unsigned CNT_W         = 19,
   parameter int unsigned LATENCY       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             s0_vsync,
   input  logic             s0_clken,
   input  logic             s0_valid,
   input  logic [23:0]      s0_data,
   input  logic             s1_vsync,
   input  logic             s1_clken,
   input  logic             s1_valid,
   input  logic [23:0]      s1_data,
   output logic             conv_vsync,
   output logic             conv_clken,
   output logic             conv_valid,
   output logic [23:0]      conv_data,
   output logic [1:0]       grant,
   output logic             res_sel,
   output logic             res_own,
   output logic             busy,
   output logic             frame_done,
   output logic             short_err,
   output logic [1:0]       drop,
   output logic [CNT_W-1:0] pix_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int unsigned     DW         = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PIX_PER_FRAME - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PIX_PER_FRAME);
   localparam logic [DW-1:0]    DRAIN_LD  = DW'(LATENCY - 1);

   state_t         state, nxt_state;
   logic [1:0]     vs_q, vs_rise, src_px;
   logic           owner, last_owner, win, take;
   logic           own_px, own_rise;
   logic           done_evt, short_evt;
   logic [1:0]     drop_evt;
   logic [DW-1:0]  drain_cnt;
   logic           load_conv, conv_idx;
   logic [LATENCY:0] sel_sr, own_sr;

   assign vs_rise  = {s1_vsync, s0_vsync} & ~vs_q;
   assign src_px   = {s1_valid & s1_clken, s0_valid & s0_clken};
   assign own_px   = src_px[owner];
   assign own_rise = vs_rise[owner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      take      = 1'b0;
      win       = 1'b0;
      done_evt  = 1'b0;
      short_evt = 1'b0;
      drop_evt  = 2'b00;
      case (state)
         IDLE: begin
            if (enable && (|vs_rise)) begin
               take      = 1'b1;
               nxt_state = RUN;
               if (&vs_rise) begin
                  // tie: the source that did not own the previous frame wins
                  win      = ~last_owner;
                  drop_evt = win ? 2'b01 : 2'b10;
               end else begin
                  win = vs_rise[1];
               end
            end
         end
         RUN: begin
            drop_evt = vs_rise & (owner ? 2'b01 : 2'b10);
            if (own_px && (pix_cnt == LAST_CNT)) begin
               done_evt  = 1'b1;
               nxt_state = DRAIN;
            end else if (own_rise) begin
               short_evt = 1'b1;
               nxt_state = DRAIN;
            end
         end
         DRAIN: begin
            drop_evt = vs_rise;
            if (drain_cnt == '0) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      grant     = 2'b00;
      busy      = (state != IDLE);
      load_conv = (state == RUN) || take;
      conv_idx  = (state == IDLE) ? win : owner;
      if (state != IDLE) grant = owner ? 2'b10 : 2'b01;
   end

   // vsync history resets high so a vsync held through reset is not taken as an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q       <= '1;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         drain_cnt  <= '0;
         pix_cnt    <= '0;
      end else begin
         vs_q <= {s1_vsync, s0_vsync};
         if (take) owner <= win;
         if (state == DRAIN) last_owner <= owner;
         if (state == RUN && nxt_state == DRAIN) drain_cnt <= DRAIN_LD;
         else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
         if (state == DRAIN && drain_cnt == '0) pix_cnt <= '0;
         else if (state == RUN && own_px && pix_cnt != FULL_CNT) pix_cnt <= pix_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_vsync <= 1'b0;
         conv_clken <= 1'b0;
         conv_valid <= 1'b0;
         conv_data  <= '0;
         frame_done <= 1'b0;
         short_err  <= 1'b0;
         drop       <= 2'b00;
         sel_sr     <= '0;
         own_sr     <= '0;
      end else begin
         conv_vsync <= load_conv & (conv_idx ? s1_vsync : s0_vsync);
         conv_clken <= load_conv & (conv_idx ? s1_clken : s0_clken);
         conv_valid <= load_conv & (conv_idx ? s1_valid : s0_valid);
         conv_data  <= load_conv ? (conv_idx ? s1_data : s0_data) : '0;
         frame_done <= done_evt;
         short_err  <= short_evt;
         drop       <= drop_evt;
         // one mux flop plus the converter pipeline
         sel_sr     <= {sel_sr[LATENCY-1:0], owner};
         own_sr     <= {own_sr[LATENCY-1:0], (state == RUN)};
      end
   end

   assign res_sel = sel_sr[LATENCY];
   assign res_own = own_sr[LATENCY];

endmodule

// File: tb/tb_ycbcr_frame_arbiter.sv
// Scoreboard bench for ycbcr_frame_arbiter with 16-pixel frames and a 3-cycle converter.
module tb_ycbcr_frame_arbiter;

   localparam int unsigned PPF = 16;
   localparam int unsigned LAT = 3;
   localparam int unsigned CW  = 5;

   logic          clk, rst_n, enable;
   logic          s0_vsync, s0_clken, s0_valid, s1_vsync, s1_clken, s1_valid;
   logic [23:0]   s0_data, s1_data, conv_data;
   logic          conv_vsync, conv_clken, conv_valid;
   logic [1:0]    grant, drop;
   logic          res_sel, res_own, busy, frame_done, short_err;
   logic [CW-1:0] pix_cnt;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   logic [24:0]   sb[$];
   int            tq_cyc[$];
   bit            tq_sel[$];
   logic [24:0]   it;

   ycbcr_frame_arbiter #(.PIX_PER_FRAME(PPF), .CNT_W(CW), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s0_vsync(s0_vsync), .s0_clken(s0_clken), .s0_valid(s0_valid), .s0_data(s0_data),
      .s1_vsync(s1_vsync), .s1_clken(s1_clken), .s1_valid(s1_valid), .s1_data(s1_data),
      .conv_vsync(conv_vsync), .conv_clken(conv_clken), .conv_valid(conv_valid),
      .conv_data(conv_data), .grant(grant), .res_sel(res_sel), .res_own(res_own),
      .busy(busy), .frame_done(frame_done), .short_err(short_err), .drop(drop),
      .pix_cnt(pix_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // converter-side monitor: pixel order/content and owner tag alignment
   always @(negedge clk) begin
      if (rst_n) begin
         if (tq_cyc.size() != 0 && tq_cyc[0] == cyc) begin
            chk("res_own", 32'(res_own), 32'd1);
            chk("res_sel", 32'(res_sel), 32'(tq_sel[0]));
            void'(tq_cyc.pop_front());
            void'(tq_sel.pop_front());
         end
         if (conv_valid && conv_clken) begin
            if (sb.size() == 0) begin
               chk("conv_extra", 32'(sb.size()), 32'd1);
            end else begin
               it = sb.pop_front();
               chk("conv_data", 32'(conv_data), 32'(it[23:0]));
               tq_cyc.push_back(cyc + int'(LAT));
               tq_sel.push_back(it[24]);
            end
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_px(input int src, input int n, input bit noise);
      logic [23:0] d, g;
      for (int i = 0; i < n; i++) begin
         if (i % 4 == 3) begin
            // stalled pixel: valid without clken must not be forwarded as a sample
            if (src == 0) begin s0_valid = 1'b1; s0_clken = 1'b0; s0_data = 24'($urandom); end
            else          begin s1_valid = 1'b1; s1_clken = 1'b0; s1_data = 24'($urandom); end
            tick();
         end
         d = 24'($urandom_range(1, 24'hFFFFFF));
         g = 24'($urandom);
         if (src == 0) begin
            s0_valid = 1'b1; s0_clken = 1'b1; s0_data = d;
            s1_valid = noise; s1_clken = noise; s1_data = g;
         end else begin
            s1_valid = 1'b1; s1_clken = 1'b1; s1_data = d;
            s0_valid = noise; s0_clken = noise; s0_data = g;
         end
         sb.push_back({1'(src), d});
         tick();
      end
      s0_valid = 1'b0; s0_clken = 1'b0;
      s1_valid = 1'b0; s1_clken = 1'b0;
   endtask

   task automatic vs_pulse(input logic [1:0] mask, input logic [1:0] exp_grant,
                           input logic [1:0] exp_drop);
      s0_vsync = mask[0];
      s1_vsync = mask[1];
      tick();
      chk("grant_after_vs", 32'(grant), 32'(exp_grant));
      chk("drop_after_vs", 32'(drop), 32'(exp_drop));
      s0_vsync = 1'b0;
      s1_vsync = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // called right after the tick that carried the last pixel of a full frame
   task automatic finish_check();
      chk("frame_done", 32'(frame_done), 32'd1);
      chk("pix_cnt_full", 32'(pix_cnt), PPF);
      chk("busy_drain", 32'(busy), 32'd1);
      for (int i = 0; i < int'(LAT); i++) begin
         tick();
         chk("drain_valid", 32'(conv_valid), 32'd0);
         if (i == 0) chk("done_once", 32'(frame_done), 32'd0);
      end
      chk("busy_end", 32'(busy), 32'd0);
      chk("grant_end", 32'(grant), 32'd0);
      chk("pix_cnt_clr", 32'(pix_cnt), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1;
      s0_vsync = 1'b0; s0_clken = 1'b0; s0_valid = 1'b0; s0_data = '0;
      s1_vsync = 1'b0; s1_clken = 1'b0; s1_valid = 1'b0; s1_data = '0;
      tick(); tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_conv_valid", 32'(conv_valid), 32'd0);
      chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
      chk("rst_res_own", 32'(res_own), 32'd0);
      rst_n = 1'b1;
      tick();

      // simultaneous starts: s0 first after reset, s1 the next time
      vs_pulse(2'b11, 2'b01, 2'b10);
      chk("drop_clear", 32'(drop), 32'd0);
      send_px(0, 16, 1'b0);
      finish_check();
      vs_pulse(2'b11, 2'b10, 2'b01);
      send_px(1, 16, 1'b0);
      finish_check();

      // short frame aborted by owner vsync
      vs_pulse(2'b01, 2'b01, 2'b00);
      send_px(0, 9, 1'b0);
      s0_vsync = 1'b1;
      tick();
      chk("short_err", 32'(short_err), 32'd1);
      chk("short_cnt", 32'(pix_cnt), 32'd9);
      chk("short_no_done", 32'(frame_done), 32'd0);
      tick();
      chk("short_once", 32'(short_err), 32'd0);
      wait_idle();
      chk("short_cnt_clr", 32'(pix_cnt), 32'd0);
      s0_vsync = 1'b0;
      tick();

      // intruding s1 frame start during s0 frame, with s1 noise pixels
      vs_pulse(2'b01, 2'b01, 2'b00);
      send_px(0, 6, 1'b1);
      s1_vsync = 1'b1;
      send_px(0, 1, 1'b1);
      chk("intrude_drop", 32'(drop), 32'b10);
      chk("intrude_grant", 32'(grant), 32'b01);
      s1_vsync = 1'b0;
      send_px(0, 9, 1'b1);
      finish_check();

      // enable dropped mid-frame still completes the frame
      vs_pulse(2'b01, 2'b01, 2'b00);
      send_px(0, 4, 1'b0);
      enable = 1'b0;
      send_px(0, 12, 1'b0);
      finish_check();
      vs_pulse(2'b01, 2'b00, 2'b00);
      chk("disabled_busy", 32'(busy), 32'd0);
      enable = 1'b1;

      // asynchronous reset in the middle of an s1 frame
      vs_pulse(2'b10, 2'b10, 2'b00);
      send_px(1, 5, 1'b0);
      tick();
      s1_vsync = 1'b1;
      rst_n = 1'b0;
      sb.delete();
      tq_cyc.delete();
      tq_sel.delete();
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_conv_valid", 32'(conv_valid), 32'd0);
      chk("arst_conv_data", 32'(conv_data), 32'd0);
      chk("arst_pix_cnt", 32'(pix_cnt), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("held_vsync_grant", 32'(grant), 32'd0);
      chk("held_vsync_busy", 32'(busy), 32'd0);
      s1_vsync = 1'b0;
      tick();
      vs_pulse(2'b10, 2'b10, 2'b00);
      send_px(1, 16, 1'b0);
      finish_check();

      for (int i = 0; i < 8; i++) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("tag_q_empty", 32'(tq_cyc.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
